// File: rtl/restador_pkg.sv
// restador_pkg: shared types and bit-level subtract helpers for restador_serie.
// Holds the FSM state type and the full-subtractor difference/borrow functions.
package restador_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic logic sub_diff(
      input logic ai,
      input logic bi,
      input logic bin
   );
      return ai ^ bi ^ bin;
   endfunction

   function automatic logic sub_borrow(
      input logic ai,
      input logic bi,
      input logic bin
   );
      return (~ai & bi) | (~(ai ^ bi) & bin);
   endfunction

endpackage

// File: rtl/restador_serie_1bit.sv
// restador_1bit: combinational full subtractor, d = ai - bi - bin.
// Ports: ai, bi, bin in; d (difference), bout (borrow out) out.
module restador_1bit
   import restador_pkg::*;
(
   input  logic ai,
   input  logic bi,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = sub_diff(ai, bi, bin);
   assign bout = sub_borrow(ai, bi, bin);

endmodule

// File: rtl/restador_serie.sv
// restador_serie: bit-serial subtractor, res = a - b, LSB first, start/done.
// Ports: clk, rst (sync high), start, a, b in; busy, done, res, borrow, ovf out.
module restador_serie
   import restador_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             borrow,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] sreg;
   logic [CNT_W-1:0] cnt;
   logic             br;
   logic             amsb;
   logic             bmsb;

   logic             d;
   logic             bout;
   logic [WIDTH-1:0] sreg_n;

   restador_1bit u_bit (
      .ai   (areg[0]),
      .bi   (breg[0]),
      .bin  (br),
      .d    (d),
      .bout (bout)
   );

   // New difference bit enters at the MSB; after WIDTH shifts
   // the LSB computed first has reached bit 0.
   assign sreg_n = {d, sreg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         areg   <= '0;
         breg   <= '0;
         sreg   <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         amsb   <= 1'b0;
         bmsb   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         res    <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         unique case (1'b1)
            (state == IDLE): begin
               done <= 1'b0;
               if (start) begin
                  areg  <= a;
                  breg  <= b;
                  amsb  <= a[WIDTH-1];
                  bmsb  <= b[WIDTH-1];
                  cnt   <= '0;
                  br    <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            (state == SHIFT): begin
               areg <= {1'b0, areg[WIDTH-1:1]};
               breg <= {1'b0, breg[WIDTH-1:1]};
               sreg <= sreg_n;
               cnt  <= cnt + CNT_W'(1);
               br   <= bout;
               if (cnt == LAST) begin
                  res    <= sreg_n;
                  borrow <= bout;
                  // d is the result MSB on the final edge
                  ovf    <= (amsb != bmsb) && (d != amsb);
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
